obi_rr_interconnect: RTL and testbench



---
 rtl/obi_rr_interconnect_pkg.sv | 24 ++
 rtl/obi_rr_interconnect_if.sv | 17 +
 rtl/obi_rr_interconnect_id_fifo.sv | 51 +++++
 rtl/obi_rr_interconnect.sv | 190 +++++++++++++++++++
 tb/tb_obi_rr_interconnect.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_rr_interconnect_pkg.sv
// Shared OBI types and constants for the round-robin interconnect.
package obi_rr_interconnect_pkg;

   localparam logic [31:0] ERR_RDATA = 32'h0;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } obi_rsp_t;

   // Target select width: every slave plus the internal error target.
   function automatic int sel_w(input int slaves);
      return $clog2(slaves + 1);
   endfunction

endpackage

// File: rtl/obi_rr_interconnect_if.sv
// N-port OBI bus bundle; "master" drives requests, "slave" returns grant/response.
interface obi_rr_interconnect_if #(
   parameter int N = 1
);
   logic [N-1:0]       req;
   logic [N-1:0]       we;
   logic [N-1:0][3:0]  be;
   logic [N-1:0][31:0] addr;
   logic [N-1:0][31:0] wdata;
   logic [N-1:0]       gnt;
   logic [N-1:0]       rvalid;
   logic [N-1:0]       err;
   logic [N-1:0][31:0] rdata;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, err, rdata);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/obi_rr_interconnect_id_fifo.sv
// In-order transaction ID FIFO: remembers which master owns each in-flight response.
module obi_rr_interconnect_id_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   // A full FIFO refuses the push even when a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/obi_rr_interconnect.sv
// OBI crossbar: address decode, per-target round-robin arbitration, in-order response
// routing through per-target ID FIFOs, and an internal decode-error target.
module obi_rr_interconnect
   import obi_rr_interconnect_pkg::*;
#(
   parameter int               MASTERS         = 3,
   parameter int               SLAVES          = 8,
   parameter int               MAX_OUTSTANDING = 2,
   parameter logic [SLAVES-1:0] FIXED_LAT_MASK = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   obi_rr_interconnect_if.slave     mst,
   obi_rr_interconnect_if.master    slv,
   input  logic [SLAVES-1:0][31:0]  slave_addr_mask_i,
   input  logic [SLAVES-1:0][31:0]  slave_addr_base_i
);
   localparam int TGTS  = SLAVES + 1;
   localparam int ERR_T = SLAVES;
   localparam int SEL_W = sel_w(SLAVES);
   localparam int MID_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [SEL_W-1:0]        sel  [MASTERS];
   logic [SEL_W-1:0]        last [MASTERS];
   logic [CNT_W-1:0]        cnt  [MASTERS];
   logic [MASTERS-1:0]      hit, elig, gnt_m, rvalid_m, err_m;
   logic [MASTERS-1:0][31:0] rdata_m;
   obi_req_t                mreq [MASTERS];

   logic [MASTERS-1:0]      cand [TGTS];
   logic [MID_W-1:0]        win  [TGTS];
   logic [MID_W-1:0]        rr   [TGTS];
   logic [MID_W-1:0]        head [TGTS];
   logic [TGTS-1:0]         any, tgt_gnt, acc, rsp_vld, pop, full, empty;
   logic [SLAVES-1:0]       fl_vld;
   logic                    err_vld;

   // First candidate strictly after ptr, wrapping around.
   function automatic logic [MID_W-1:0] rr_pick(input logic [MASTERS-1:0] c,
                                                input logic [MID_W-1:0]   ptr);
      logic [MID_W-1:0] pick;
      logic             found;
      pick  = ptr;
      found = 1'b0;
      for (int m = 0; m < MASTERS; m++) begin
         if (!found && c[m] && (MID_W'(m) > ptr)) begin
            pick  = MID_W'(m);
            found = 1'b1;
         end
      end
      for (int m = 0; m < MASTERS; m++) begin
         if (!found && c[m] && (MID_W'(m) <= ptr)) begin
            pick  = MID_W'(m);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      for (int m = 0; m < MASTERS; m++) begin
         sel[m] = SEL_W'(ERR_T);
         hit[m] = 1'b0;
         mreq[m] = '{we: mst.we[m], be: mst.be[m], addr: mst.addr[m], wdata: mst.wdata[m]};
         for (int s = 0; s < SLAVES; s++) begin
            if (!hit[m] && ((mst.addr[m] & slave_addr_mask_i[s]) == slave_addr_base_i[s])) begin
               sel[m] = SEL_W'(s);
               hit[m] = 1'b1;
            end
         end
      end
   end

   // A master may not switch target while responses from its previous one are pending.
   always_comb begin
      for (int m = 0; m < MASTERS; m++) begin
         elig[m] = mst.req[m] && (cnt[m] < CNT_W'(MAX_OUTSTANDING)) &&
                   ((cnt[m] == '0) || (last[m] == sel[m])) && !full[sel[m]];
      end
   end

   always_comb begin
      for (int t = 0; t < TGTS; t++) begin
         for (int m = 0; m < MASTERS; m++) begin
            cand[t][m] = elig[m] && (sel[m] == SEL_W'(t));
         end
         any[t] = |cand[t];
         win[t] = rr_pick(cand[t], rr[t]);
      end
      for (int s = 0; s < SLAVES; s++) begin
         tgt_gnt[s] = FIXED_LAT_MASK[s] | slv.gnt[s];
      end
      tgt_gnt[ERR_T] = 1'b1;
      acc = any & tgt_gnt;
   end

   always_comb begin
      for (int m = 0; m < MASTERS; m++) begin
         gnt_m[m] = elig[m] && acc[sel[m]] && (win[sel[m]] == MID_W'(m));
      end
   end

   always_comb begin
      for (int s = 0; s < SLAVES; s++) begin
         slv.req[s]   = any[s];
         slv.we[s]    = mreq[win[s]].we;
         slv.be[s]    = mreq[win[s]].be;
         slv.addr[s]  = mreq[win[s]].addr;
         slv.wdata[s] = mreq[win[s]].wdata;
      end
   end

   // Responses arriving with no recorded owner (e.g. after a reset) are dropped.
   always_comb begin
      for (int s = 0; s < SLAVES; s++) begin
         rsp_vld[s] = FIXED_LAT_MASK[s] ? fl_vld[s] : slv.rvalid[s];
      end
      rsp_vld[ERR_T] = err_vld;
      pop = rsp_vld & ~empty;
   end

   always_comb begin
      rvalid_m = '0;
      err_m    = '0;
      rdata_m  = '0;
      for (int s = 0; s < SLAVES; s++) begin
         for (int m = 0; m < MASTERS; m++) begin
            if (pop[s] && (head[s] == MID_W'(m))) begin
               rvalid_m[m] = 1'b1;
               rdata_m[m]  = slv.rdata[s];
            end
         end
      end
      for (int m = 0; m < MASTERS; m++) begin
         if (pop[ERR_T] && (head[ERR_T] == MID_W'(m))) begin
            rvalid_m[m] = 1'b1;
            err_m[m]    = 1'b1;
            rdata_m[m]  = ERR_RDATA;
         end
      end
   end

   assign mst.gnt    = gnt_m;
   assign mst.rvalid = rvalid_m;
   assign mst.err    = err_m;
   assign mst.rdata  = rdata_m;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int m = 0; m < MASTERS; m++) begin
            cnt[m]  <= '0;
            last[m] <= '0;
         end
         for (int t = 0; t < TGTS; t++) begin
            rr[t] <= MID_W'(MASTERS - 1);
         end
         fl_vld  <= '0;
         err_vld <= 1'b0;
      end else begin
         for (int m = 0; m < MASTERS; m++) begin
            if (gnt_m[m] && !rvalid_m[m])      cnt[m] <= cnt[m] + CNT_W'(1);
            else if (!gnt_m[m] && rvalid_m[m]) cnt[m] <= cnt[m] - CNT_W'(1);
            if (gnt_m[m]) last[m] <= sel[m];
         end
         for (int t = 0; t < TGTS; t++) begin
            if (acc[t]) rr[t] <= win[t];
         end
         fl_vld  <= FIXED_LAT_MASK & acc[SLAVES-1:0];
         err_vld <= acc[ERR_T];
      end
   end

   for (genvar t = 0; t < TGTS; t++) begin : g_fifo
      obi_rr_interconnect_id_fifo #(
         .DEPTH (MAX_OUTSTANDING),
         .WIDTH (MID_W)
      ) u_fifo (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .push   (acc[t]),
         .din    (win[t]),
         .pop    (pop[t]),
         .full   (full[t]),
         .empty  (empty[t]),
         .head   (head[t])
      );
   end

endmodule

// File: tb/tb_obi_rr_interconnect.sv
// Scoreboard bench for obi_rr_interconnect: directed scenarios with a behavioural slave model.
module tb_obi_rr_interconnect;

   localparam logic [31:0] K = 32'h0234_567C;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_ni;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   lat [8];

   logic [7:0][31:0] mask, base;
   logic [7:0]       rv;
   logic [7:0][31:0] rd;

   exp_t        exp_q [3][$];
   logic [31:0] paddr [8][$];
   int          pdue  [8][$];

   obi_rr_interconnect_if #(.N(3)) mst_bus ();
   obi_rr_interconnect_if #(.N(8)) slv_bus ();

   obi_rr_interconnect #(
      .MASTERS         (3),
      .SLAVES          (8),
      .MAX_OUTSTANDING (2),
      .FIXED_LAT_MASK  (8'h01)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .mst               (mst_bus),
      .slv               (slv_bus),
      .slave_addr_mask_i (mask),
      .slave_addr_base_i (base)
   );

   always #5 clk = ~clk;

   assign slv_bus.gnt    = '1;
   assign slv_bus.err    = '0;
   assign slv_bus.rvalid = rv;
   assign slv_bus.rdata  = rd;

   // Slave model: each accepted request answers lat[s] cycles later with addr ^ K.
   initial begin
      rv = '0;
      rd = '0;
   end
   always @(posedge clk) begin
      for (int s = 0; s < 8; s++) begin
         if (slv_bus.req[s] && slv_bus.gnt[s]) begin
            paddr[s].push_back(slv_bus.addr[s]);
            pdue[s].push_back(cyc + lat[s]);
         end
         if (pdue[s].size() > 0 && pdue[s][0] <= cyc + 1) begin
            rv[s] <= 1'b1;
            rd[s] <= paddr[s][0] ^ K;
            void'(pdue[s].pop_front());
            void'(paddr[s].pop_front());
         end else begin
            rv[s] <= 1'b0;
            rd[s] <= '0;
         end
      end
      cyc <= cyc + 1;
   end

   function automatic exp_t exp_of(input logic [31:0] a);
      exp_t e;
      if (a[31:28] >= 4'd1 && a[31:28] <= 4'd8) e = '{err: 1'b0, rdata: a ^ K};
      else                                     e = '{err: 1'b1, rdata: 32'h0};
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: every response the DUT presents is matched against the head expectation.
   always @(negedge clk) begin
      for (int m = 0; m < 3; m++) begin
         if (mst_bus.rvalid[m] === 1'b1) begin
            n_tests++;
            if (exp_q[m].size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected m%0d: got rdata %0h, required no response", m, mst_bus.rdata[m]);
            end else begin
               exp_t e;
               e = exp_q[m].pop_front();
               if (mst_bus.err[m] !== e.err || mst_bus.rdata[m] !== e.rdata) begin
                  n_fail++;
                  $display("FAIL sb_rsp m%0d: got err %0b rdata %0h, required err %0b rdata %0h",
                           m, mst_bus.err[m], mst_bus.rdata[m], e.err, e.rdata);
               end
            end
         end
      end
   end

   task automatic issue(input int m, input logic [31:0] a, output int waits);
      bit got;
      got   = 0;
      waits = 0;
      mst_bus.req[m]   = 1'b1;
      mst_bus.we[m]    = 1'b0;
      mst_bus.be[m]    = 4'hF;
      mst_bus.addr[m]  = a;
      mst_bus.wdata[m] = ~a;
      while (!got && waits < 20) begin
         @(negedge clk);
         if (mst_bus.gnt[m]) begin
            got = 1;
            exp_q[m].push_back(exp_of(a));
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      mst_bus.req[m] = 1'b0;
      if (!got) chk("gnt_timeout", 64'(waits), 64'(0));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_drained(input string name);
      for (int m = 0; m < 3; m++) chk(name, 64'(exp_q[m].size()), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, w1, w2, w3;
      rst_ni = 1'b0;
      mst_bus.req = '0; mst_bus.we = '0; mst_bus.be = '0;
      mst_bus.addr = '0; mst_bus.wdata = '0;
      for (int s = 0; s < 8; s++) begin
         mask[s] = 32'hF000_0000;
         base[s] = 32'(s + 1) << 28;
         lat[s]  = 1;
      end

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rvalid", 64'(mst_bus.rvalid), 64'(0));
      chk("rst_err", 64'(mst_bus.err), 64'(0));
      chk("rst_rdata0", 64'(mst_bus.rdata[0]), 64'(0));
      chk("rst_slave_req", 64'(slv_bus.req), 64'(0));
      chk("rst_rr", 64'(dut.rr[1]), 64'(2));
      @(posedge clk); #1;
      rst_ni = 1'b1;
      idle(1);

      // Fixed-latency RAM read
      issue(0, 32'h1000_0004, w);
      chk("ram_gnt_wait", 64'(w), 64'(0));
      @(negedge clk);
      chk("ram_rvalid", 64'(mst_bus.rvalid[0]), 64'(1));
      chk("ram_rdata", 64'(mst_bus.rdata[0]), 64'h1234_5678);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ram_cnt", 64'(dut.cnt[0]), 64'(0));
      idle(1);

      // Round-robin among three masters on slave 1
      for (int m = 0; m < 3; m++) begin
         mst_bus.req[m]  = 1'b1;
         mst_bus.we[m]   = 1'b0;
         mst_bus.be[m]   = 4'hF;
         mst_bus.addr[m] = 32'h2000_0000 | 32'(m << 4);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rr_order", 64'(mst_bus.gnt), 64'(3'b001 << (i % 3)));
         for (int m = 0; m < 3; m++)
            if (mst_bus.gnt[m]) exp_q[m].push_back(exp_of(mst_bus.addr[m]));
         @(posedge clk); #1;
      end
      mst_bus.req = '0;
      idle(4);
      chk_drained("rr_drained");

      // Unmapped address goes to the error target
      mst_bus.req[1]  = 1'b1;
      mst_bus.addr[1] = 32'hF000_0000;
      @(negedge clk);
      chk("err_gnt", 64'(mst_bus.gnt[1]), 64'(1));
      chk("err_no_slave_req", 64'(slv_bus.req), 64'(0));
      if (mst_bus.gnt[1]) exp_q[1].push_back(exp_of(32'hF000_0000));
      @(posedge clk); #1;
      mst_bus.req[1] = 1'b0;
      @(negedge clk);
      chk("err_rvalid", 64'(mst_bus.rvalid[1]), 64'(1));
      chk("err_flag", 64'(mst_bus.err[1]), 64'(1));
      chk("err_rdata", 64'(mst_bus.rdata[1]), 64'(0));
      idle(2);

      // Outstanding limit: third request waits for the first response
      lat[2] = 3;
      issue(1, 32'h3000_0000, w1);
      issue(1, 32'h3000_0004, w2);
      issue(1, 32'h3000_0008, w3);
      chk("max_out_w1", 64'(w1), 64'(0));
      chk("max_out_w2", 64'(w2), 64'(0));
      chk("max_out_w3", 64'(w3), 64'(2));
      idle(6);
      chk_drained("max_out_drained");
      chk("max_out_cnt", 64'(dut.cnt[1]), 64'(0));

      // Ordering: no target switch while a response is pending
      lat[3] = 4;
      issue(2, 32'h4000_0000, w1);
      issue(2, 32'h5000_0000, w2);
      chk("order_w1", 64'(w1), 64'(0));
      chk("order_w2", 64'(w2), 64'(4));
      idle(4);
      chk_drained("order_drained");

      // Reset with two transactions in flight
      lat[1] = 5;
      issue(0, 32'h2000_0000, w1);
      issue(0, 32'h2000_0004, w2);
      chk("flush_cnt_before", 64'(dut.cnt[0]), 64'(2));
      rst_ni = 1'b0;
      exp_q[0].delete();
      @(negedge clk);
      chk("flush_rst_rvalid", 64'(mst_bus.rvalid), 64'(0));
      @(posedge clk); #1;
      rst_ni = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("flush_rvalid", 64'(mst_bus.rvalid), 64'(0));
      end
      for (int m = 0; m < 3; m++) chk("flush_cnt", 64'(dut.cnt[m]), 64'(0));
      chk_drained("final_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
